logic_unit_pipe: RTL and testbench
==================================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits, legal range 1..64.
REQ-002 SHALL have parameter STAGES, default 2: pipeline depth in registered stages, legal range 1..4.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: upstream presents op/a/b.
REQ-006 SHALL have port in_ready, output, 1: block accepts input this cycle.
REQ-007 SHALL have port op, input, 3: operation select, encoding per REQ-012.
REQ-008 SHALL have ports a and b, input, WIDTH each: operands (b ignored for NOT and PASS).
REQ-009 SHALL have port out_valid, output, 1: result f is valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts result.
REQ-011 SHALL have port f, output, WIDTH: registered result.

Function
REQ-012 SHALL encode op as: 0 NOT (~a), 1 AND, 2 OR, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 PASS (a).
REQ-013 SHALL compute the result combinationally before the first stage register; later stages carry data unchanged.
REQ-014 SHALL count a transfer on either handshake only on a cycle where valid and ready are both 1.
REQ-015 SHALL present an accepted input at f exactly STAGES cycles after acceptance when out_ready is held 1.
REQ-016 SHALL sustain one transfer per cycle when out_ready is held 1.
REQ-017 SHALL advance a stage when that stage is empty or the stage after it advances; the last stage advances when out_ready=1.
REQ-018 SHALL drive in_ready=1 when stage 1 is empty or stage 1 advances in the same cycle.
REQ-019 SHALL accept a new input when the pipeline is full and out_ready=1 in the same cycle (no bubble).
REQ-020 SHALL hold f and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL neither drop nor duplicate a result under any out_ready pattern.
REQ-022 SHALL accept changes to op on any accepted beat; each beat uses its own op.

Reset
REQ-023 SHALL, with rst_n=0 at a clock edge, clear all stage valid bits and set out_valid=0 and f=0.
REQ-024 SHALL discard all in-flight beats when reset is asserted mid-operation; no result from before reset reaches f afterwards.
REQ-025 SHALL drive in_ready=0 while rst_n=0.
REQ-026 SHALL allow acceptance on the first clock edge after rst_n returns to 1.

Configuration
REQ-027 SHALL, with macro LOGIC_UNIT_PIPE_ZERO_FLAG_EN defined, add output port zero (1 bit), equal to 1 exactly when the result f is all zeros, pipelined alongside f and reset to 0.
REQ-028 SHALL, without LOGIC_UNIT_PIPE_ZERO_FLAG_EN, have no zero port and no zero-detect logic.

Structure
REQ-029 SHALL take the op encoding (3-bit enum logic_op_t with the eight values of REQ-012) from shared package logic_unit_pkg.
REQ-030 SHALL implement each stage as sub-module logic_pipe_stage (valid/ready register slice, parametrised by data width), instantiated STAGES times.

Verification
REQ-031 Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, f=0, in_ready=0; in_ready=1 on the first cycle after release.
REQ-032 Op sweep, WIDTH=8, a=8'hA5, b=8'h0F, op 0..7, out_ready=1 -> f = 5A,05,AF,AA,FA,50,55,A5, each STAGES cycles after its input.
REQ-033 Backpressure, STAGES=2, 4 back-to-back beats, out_ready=0 for 5 cycles then 1 -> in_ready falls after 2 beats are held; all 4 results appear in order; f stays stable while stalled.
REQ-034 Full pipeline with out_ready=1 and in_valid=1 for 20 cycles -> in_ready stays 1 and there are 20 outputs with no bubble.
REQ-035 Reset mid-stream after 3 accepted beats -> no stale out_valid after release; the next beat is NOT a=8'h00 -> f=8'hFF.
REQ-036 ZERO_FLAG_EN build: XOR a=b=8'h3C -> zero=1, aligned with f=8'h00; then OR of 8'h01 with 8'h00 -> zero=0.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared op encoding for the pipelined bitwise logic unit.
package logic_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } logic_op_t;

endpackage

// File: rtl/logic_pipe_stage.sv
// One valid/ready register slice; loads whenever empty or its consumer takes the current beat.
module logic_pipe_stage #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready_c,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data
);

  logic advance_c;

  assign advance_c = !m_valid || m_ready;
  // Held low during reset so nothing upstream counts a transfer.
  assign s_ready_c = rst_n && advance_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (advance_c) begin
      m_valid <= s_valid;
      if (s_valid) m_data <= s_data;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit followed by STAGES valid/ready register slices.
// Optional zero flag output enabled by LOGIC_UNIT_PIPE_ZERO_FLAG_EN.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f
`ifdef LOGIC_UNIT_PIPE_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

`ifdef LOGIC_UNIT_PIPE_ZERO_FLAG_EN
  localparam int unsigned DW = WIDTH + 1;
`else
  localparam int unsigned DW = WIDTH;
`endif

  logic [WIDTH-1:0] res_c;
  logic [STAGES:0]  vld;
  logic [STAGES:0]  rdy;
  logic [DW-1:0]    dat [STAGES+1];

  // Result is formed before the first register; later stages only carry it.
  always_comb begin
    res_c = '0;
    case (logic_op_t'(op))
      OP_NOT:  res_c = ~a;
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_XOR:  res_c = a ^ b;
      OP_NAND: res_c = ~(a & b);
      OP_NOR:  res_c = ~(a | b);
      OP_XNOR: res_c = ~(a ^ b);
      default: res_c = a;
    endcase
  end

`ifdef LOGIC_UNIT_PIPE_ZERO_FLAG_EN
  assign dat[0] = {(res_c == '0), res_c};
  assign zero   = dat[STAGES][WIDTH];
`else
  assign dat[0] = res_c;
`endif

  assign vld[0]      = in_valid;
  assign in_ready    = rdy[0];
  assign rdy[STAGES] = out_ready;
  assign out_valid   = vld[STAGES];
  assign f           = dat[STAGES][WIDTH-1:0];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic_pipe_stage #(.DW(DW)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (vld[i]),
      .s_ready_c (rdy[i]),
      .s_data    (dat[i]),
      .m_valid   (vld[i+1]),
      .m_ready   (rdy[i+1]),
      .m_data    (dat[i+1])
    );
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH=8, STAGES=2); zero-flag checks when LOGIC_UNIT_PIPE_ZERO_FLAG_EN is set.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STAGES = 2;

  // Per-op truth table indexed by {a_bit, b_bit}.
  localparam logic [3:0] TT [8] = '{4'b0011, 4'b1000, 4'b1110, 4'b0110,
                                    4'b0111, 4'b0001, 4'b1001, 4'b1100};

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] f;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
`ifdef LOGIC_UNIT_PIPE_ZERO_FLAG_EN
  logic             zero;
`endif

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic sb_en = 1'b0;
  logic prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_f = '0;
  logic [WIDTH-1:0] exp_q [$];

  logic_unit_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f)
`ifdef LOGIC_UNIT_PIPE_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] model(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    logic [3:0]       t;
    t = TT[o];
    for (int i = 0; i < WIDTH; i++) r[i] = t[{x[i], y[i]}];
    return r;
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chkw(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard: in-order expected results, plus stall-stability tracking.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk1("stall_valid", out_valid, 1'b1);
        chkw("stall_f", f, prev_f);
      end
      if (sb_en && in_valid && in_ready) exp_q.push_back(model(op, a, b));
      if (sb_en && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra_out: got f=%h with no beat outstanding at %0t", f, $time);
        end else begin
          logic [WIDTH-1:0] e;
          e = exp_q.pop_front();
          chkw("sb_f", f, e);
`ifdef LOGIC_UNIT_PIPE_ZERO_FLAG_EN
          chk1("sb_zero", zero, (e == '0));
`endif
          pops++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_f     = f;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat until accepted (bounded), then drop in_valid.
  task automatic send(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic done;
    done = 1'b0;
    in_valid = 1'b1; op = o; a = x; b = y;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 within 50 cycles at %0t", $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t             tbl [8];
    logic [WIDTH-1:0] sweep_f [8];
    vec_t             bp [4];
    int               bi;
    int               pops0;

    sweep_f = '{8'h5A, 8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hA5};
    for (int i = 0; i < 8; i++) tbl[i] = '{3'(i), 8'hA5, 8'h0F, sweep_f[i]};
    for (int i = 0; i < 4; i++) bp[i] = '{3'(i + 1), 8'(8'h11 * (i + 1)), 8'h3C, 8'h00};

    // Reset held with in_valid high
    rst_n = 1'b0; in_valid = 1'b1; op = 3'd7; a = 8'h3C; b = 8'h00; out_ready = 1'b1;
    tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk1("rst_out_valid", out_valid, 1'b0);
      chkw("rst_f", f, 8'h00);
      chk1("rst_in_ready", in_ready, 1'b0);
      tick();
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rel_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (STAGES - 1) tick();
    @(negedge clk);
    chk1("rel_first_valid", out_valid, 1'b1);
    chkw("rel_first_f", f, 8'h3C);
    tick();
    repeat (3) tick();

    // Op sweep, back-to-back, checked exactly STAGES cycles after each input
    for (int i = 0; i < 8 + STAGES; i++) begin
      if (i < 8) begin
        in_valid = 1'b1; op = tbl[i].op; a = tbl[i].a; b = tbl[i].b;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 8) chk1("sweep_in_ready", in_ready, 1'b1);
      if (i >= STAGES) begin
        chk1("sweep_valid", out_valid, 1'b1);
        chkw("sweep_f", f, tbl[i - STAGES].f);
      end
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();

    // Backpressure: out_ready low for 5 cycles with 4 beats offered
    sb_en = 1'b1; out_ready = 1'b0; bi = 0; pops0 = pops;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; op = bp[bi].op; a = bp[bi].a; b = bp[bi].b;
      @(negedge clk);
      if (c < 2) chk1("bp_in_ready_open", in_ready, 1'b1);
      else begin
        chk1("bp_in_ready_full", in_ready, 1'b0);
        chkw("bp_f_head", f, model(bp[0].op, bp[0].a, bp[0].b));
      end
      if (in_ready) bi++;
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (bi < 4 || exp_q.size() > 0); c++) begin
      in_valid = (bi < 4);
      if (bi < 4) begin
        op = bp[bi].op; a = bp[bi].a; b = bp[bi].b;
      end
      @(negedge clk);
      if (in_valid && in_ready) bi++;
      tick();
    end
    in_valid = 1'b0;
    chki("bp_accepted", bi, 4);
    chki("bp_outputs", pops - pops0, 4);

    // Full throughput for 20 cycles
    pops0 = pops;
    for (int i = 0; i < 20 + STAGES; i++) begin
      in_valid = (i < 20);
      op = 3'($urandom_range(7)); a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      if (i < 20) chk1("tp_in_ready", in_ready, 1'b1);
      if (i >= STAGES) chk1("tp_no_bubble", out_valid, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    chki("tp_outputs", pops - pops0, 20);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      op = 3'($urandom_range(7)); a = 8'($urandom); b = 8'($urandom);
      if ($urandom_range(15) == 0) a = b;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    chki("rand_drained", exp_q.size(), 0);
    sb_en = 1'b0;

    // Reset mid-stream after 3 accepted beats
    send(3'd7, 8'h11, 8'h00);
    send(3'd7, 8'h22, 8'h00);
    send(3'd7, 8'h33, 8'h00);
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chkw("mid_rst_f", f, 8'h00);
    chk1("mid_rst_in_ready", in_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk1("mid_no_stale", out_valid, 1'b0);
      tick();
    end
    send(3'd0, 8'h00, 8'h5A);
    repeat (STAGES - 1) tick();
    @(negedge clk);
    chk1("mid_next_valid", out_valid, 1'b1);
    chkw("mid_next_f", f, 8'hFF);
    tick();

`ifdef LOGIC_UNIT_PIPE_ZERO_FLAG_EN
    // Zero flag travels with its result
    send(3'd3, 8'h3C, 8'h3C);
    repeat (STAGES - 1) tick();
    @(negedge clk);
    chk1("zf_valid0", out_valid, 1'b1);
    chkw("zf_f0", f, 8'h00);
    chk1("zf_zero1", zero, 1'b1);
    tick();
    send(3'd2, 8'h01, 8'h00);
    repeat (STAGES - 1) tick();
    @(negedge clk);
    chk1("zf_valid1", out_valid, 1'b1);
    chkw("zf_f1", f, 8'h01);
    chk1("zf_zero0", zero, 1'b0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
